egress_ptp_arbiter: RTL and testbench
=====================================

Name: egress_ptp_arbiter

Overview:
Packet-atomic 2:1 arbiter that shares the MAC TX AXI-Stream port between two requesters: port 0 carries PTP event frames, and port 1 carries general user traffic.
- It sits upstream of the egress merge block, whose user-side stream it drives.
- PTP frames get strict priority, bounded by an anti-starvation limit so user traffic always makes progress.
- It tags each beat with its source and keeps per-source frame counters for software.

Parameters:
- Stream_Width, 64, stream width in bytes (legal: 8, 16, 32, 64); tdata is Stream_Width*8 bits.
- MAX_HOLD, 4, maximum consecutive PTP frames granted while user port 1 is waiting (legal: 1..255).

Ports:
- clk  in  1  single clock for all logic
- resetn  in  1  reset, asynchronous assert, active-low
- ptp_s_axis_tdata  in  Stream_Width*8  PTP frame data
- ptp_s_axis_tkeep  in  Stream_Width  byte enables
- ptp_s_axis_tlast  in  1  end of frame
- ptp_s_axis_tuser  in  1  1 = request TX timestamp for this frame
- ptp_s_axis_tvalid  in  1  beat valid
- ptp_s_axis_tready  out  1  beat accepted
- usr_s_axis_tdata/tkeep/tlast/tuser/tvalid/tready  same widths and directions as the ptp_s_axis_* ports  user traffic
- m_axis_tdata  out  Stream_Width*8  merged data
- m_axis_tkeep  out  Stream_Width  merged byte enables
- m_axis_tlast  out  1  end of frame
- m_axis_tuser  out  2  [0] timestamp request, [1] source (0 = PTP, 1 = user)
- m_axis_tvalid  out  1  merged valid
- m_axis_tready  in  1  downstream ready
- grant  out  2  one-hot current owner, 00 = idle
- ptp_frame_cnt  out  32  PTP frames completed
- usr_frame_cnt  out  32  user frames completed

Behaviour:
Clock and reset:
- One clock, clk.
- Reset resetn is asynchronous and active-low.

Reset values (all outputs, asynchronously on reset):
- State = IDLE; grant = 00.
- m_axis_tvalid = 0; ptp_s_axis_tready = 0; usr_s_axis_tready = 0.
- Both frame counters = 0; hold counter = 0.

States: IDLE, GNT_PTP, GNT_USR.

IDLE:
- All treadys = 0 and m_axis_tvalid = 0.
- Decision is made on the registered state; the data path is dead this cycle, so there is exactly one bubble cycle per frame.
- If ptp tvalid and (hold < MAX_HOLD or usr tvalid = 0): go to GNT_PTP.
- Else if usr tvalid: go to GNT_USR.
- Else: stay in IDLE.

GNT_x (combinational pass-through, zero latency):
- m_axis_tdata/tkeep/tlast/tvalid follow port x.
- x_tready = m_axis_tready; the other port's tready = 0.
- m_axis_tuser = {x==usr, x_tuser}.
- A beat transfers when m_axis_tvalid and m_axis_tready are both 1.
- A transfer with tlast = 1 returns the state to IDLE and increments that port's frame counter.
- The counter wraps from 0xFFFFFFFF to 0.

Hold counter (8 bits):
- Increments on PTP frame completion while usr tvalid = 1.
- Saturates at MAX_HOLD.
- Clears on user frame completion, and clears on PTP frame completion while usr tvalid = 0.

Frame atomicity and idle gaps:
- Grant never changes mid-frame.
- tvalid dropping mid-frame holds the grant; output tvalid = 0 until the frame resumes.

Simultaneous requests in IDLE:
- PTP wins unless the hold counter equals MAX_HOLD.

Back-pressure:
- m_axis_tready = 0 stalls the granted source with no data loss.
- Outputs must not change while tvalid = 1 and tready = 0; this is guaranteed by the upstream AXIS rule.

Reset mid-frame:
- Frame is abandoned and the state returns to IDLE.
- The partial frame is not counted.
- Downstream sees tvalid drop; downstream frame recovery is outside this block.

grant:
- Registered one-hot copy of the state.
- Valid in the cycle the state is GNT_x.

Decomposition:
Shared package (egress_pkg):
- State enum {IDLE, GNT_PTP, GNT_USR}.
- SRC_PTP = 0, SRC_USR = 1 tuser source encodings.
- Hold counter width constant (8).

Sub-module: egress_frame_counter, 32-bit wrap counter with increment enable, instantiated twice.

Test Plan:
- Only the user port active, three frames of 2/1/5 beats with m_axis_tready = 1 -> output order preserved, one idle cycle between frames, m_axis_tuser[1] = 1, usr_frame_cnt = 3, ptp_frame_cnt = 0.
- Both ports continuously valid, MAX_HOLD = 4, single-beat frames -> grant sequence P,P,P,P,U,P,P,P,P,U; no beats interleaved within a frame.
- PTP frame with tuser = 1 while m_axis_tready toggles 1,0,0,1 -> data stable during stalls, m_axis_tuser = 2'b01 on every beat, no beat lost or duplicated.
- Granted frame stalls mid-way (tvalid = 0 for 3 cycles) while the other port is valid -> grant held, other port's tready stays 0, frame completes intact.
- Assert resetn = 0 on the 2nd beat of a 4-beat frame -> outputs go to reset values immediately; after release both counters read 0 and the next frame arbitrates normally.
- Preload ptp_frame_cnt to 0xFFFFFFFF via force, then complete one frame -> counter reads 0.

Source files
------------

// File: rtl/egress_ptp_arbiter_pkg.sv
// Shared types and constants for the egress PTP/user stream arbiter.
package egress_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_PTP = 2'd1,
    GNT_USR = 2'd2
  } state_t;

  localparam logic        SRC_PTP = 1'b0;
  localparam logic        SRC_USR = 1'b1;
  localparam int unsigned HOLD_W  = 8;

  // grant[0] = PTP owner, grant[1] = user owner
  function automatic logic [1:0] state_to_grant(input state_t s);
    logic [1:0] g;
    g = '0;
    case (s)
      GNT_PTP: g = 2'b01;
      GNT_USR: g = 2'b10;
      default: g = '0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/egress_ptp_arbiter_if.sv
// AXI-Stream bundle used for the two requester ports and the merged output.
interface egress_axis_if #(
  parameter int unsigned BYTES  = 64,
  parameter int unsigned USER_W = 1
);
  logic [BYTES*8-1:0] tdata;
  logic [BYTES-1:0]   tkeep;
  logic               tlast;
  logic [USER_W-1:0]  tuser;
  logic               tvalid;
  logic               tready;

  modport master (output tdata, output tkeep, output tlast, output tuser,
                  output tvalid, input tready);
  modport slave  (input tdata, input tkeep, input tlast, input tuser,
                  input tvalid, output tready);
endinterface

// File: rtl/egress_ptp_arbiter_frame_counter.sv
// Wrapping event counter with increment enable, used for per-source frame counts.
module egress_frame_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/egress_ptp_arbiter.sv
// Packet-atomic 2:1 arbiter: PTP frames have strict priority, bounded by an
// anti-starvation hold limit so user frames keep moving.
module egress_ptp_arbiter
  import egress_pkg::*;
#(
  parameter int unsigned Stream_Width = 64,
  parameter int unsigned MAX_HOLD     = 4
) (
  input  logic          clk,
  input  logic          resetn,
  egress_axis_if.slave  ptp_s_axis,
  egress_axis_if.slave  usr_s_axis,
  egress_axis_if.master m_axis,
  output logic [1:0]    grant,
  output logic [31:0]   ptp_frame_cnt,
  output logic [31:0]   usr_frame_cnt
);

  localparam logic [HOLD_W-1:0] L_MAX_HOLD = HOLD_W'(MAX_HOLD);

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_grant;
  logic [HOLD_W-1:0]   r_hold;
  logic [HOLD_W-1:0]   w_hold_nxt;
  logic                w_ptp_done;
  logic                w_usr_done;
  logic [Stream_Width*8-1:0] w_zero_data;

  assign w_zero_data = '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_next;
      r_grant <= state_to_grant(w_next);
      r_hold  <= w_hold_nxt;
    end
  end

  // IDLE is a dead cycle on the data path: one bubble between frames.
  always_comb begin
    w_next             = r_state;
    m_axis.tdata       = w_zero_data;
    m_axis.tkeep       = '0;
    m_axis.tlast       = 1'b0;
    m_axis.tuser       = '0;
    m_axis.tvalid      = 1'b0;
    ptp_s_axis.tready  = 1'b0;
    usr_s_axis.tready  = 1'b0;
    w_ptp_done         = 1'b0;
    w_usr_done         = 1'b0;

    case (r_state)
      IDLE: begin
        if (ptp_s_axis.tvalid && ((r_hold < L_MAX_HOLD) || !usr_s_axis.tvalid)) begin
          w_next = GNT_PTP;
        end else if (usr_s_axis.tvalid) begin
          w_next = GNT_USR;
        end
      end
      GNT_PTP: begin
        m_axis.tdata      = ptp_s_axis.tdata;
        m_axis.tkeep      = ptp_s_axis.tkeep;
        m_axis.tlast      = ptp_s_axis.tlast;
        m_axis.tuser      = {SRC_PTP, ptp_s_axis.tuser[0]};
        m_axis.tvalid     = ptp_s_axis.tvalid;
        ptp_s_axis.tready = m_axis.tready;
        w_ptp_done        = ptp_s_axis.tvalid && m_axis.tready && ptp_s_axis.tlast;
        if (w_ptp_done) begin
          w_next = IDLE;
        end
      end
      GNT_USR: begin
        m_axis.tdata      = usr_s_axis.tdata;
        m_axis.tkeep      = usr_s_axis.tkeep;
        m_axis.tlast      = usr_s_axis.tlast;
        m_axis.tuser      = {SRC_USR, usr_s_axis.tuser[0]};
        m_axis.tvalid     = usr_s_axis.tvalid;
        usr_s_axis.tready = m_axis.tready;
        w_usr_done        = usr_s_axis.tvalid && m_axis.tready && usr_s_axis.tlast;
        if (w_usr_done) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Hold counts back-to-back PTP frames only while the user port is waiting.
  always_comb begin
    w_hold_nxt = r_hold;
    if (w_usr_done) begin
      w_hold_nxt = '0;
    end else if (w_ptp_done) begin
      if (usr_s_axis.tvalid) begin
        if (r_hold < L_MAX_HOLD) begin
          w_hold_nxt = r_hold + 1'b1;
        end
      end else begin
        w_hold_nxt = '0;
      end
    end
  end

  assign grant = r_grant;

  egress_frame_counter #(.WIDTH(32)) u_ptp_cnt (
    .clk   (clk),
    .rst_n (resetn),
    .i_inc (w_ptp_done),
    .o_cnt (ptp_frame_cnt)
  );

  egress_frame_counter #(.WIDTH(32)) u_usr_cnt (
    .clk   (clk),
    .rst_n (resetn),
    .i_inc (w_usr_done),
    .o_cnt (usr_frame_cnt)
  );

endmodule

// File: tb/tb_egress_ptp_arbiter.sv
// Randomized bench for egress_ptp_arbiter with a frame-level reference model.
module tb_egress_ptp_arbiter;

  localparam int unsigned SW   = 8;
  localparam int unsigned MAXH = 4;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
  } beat_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  grant;
  logic [31:0] pcnt, ucnt;

  egress_axis_if #(.BYTES(SW), .USER_W(1)) ptp_if ();
  egress_axis_if #(.BYTES(SW), .USER_W(1)) usr_if ();
  egress_axis_if #(.BYTES(SW), .USER_W(2)) m_if ();

  egress_ptp_arbiter #(.Stream_Width(SW), .MAX_HOLD(MAXH)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .ptp_s_axis    (ptp_if),
    .usr_s_axis    (usr_if),
    .m_axis        (m_if),
    .grant         (grant),
    .ptp_frame_cnt (pcnt),
    .usr_frame_cnt (ucnt)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  beat_t       pq[$];
  beat_t       uq[$];
  logic        pv = 1'b0, uv = 1'b0;
  logic        p_acc = 1'b0, u_acc = 1'b0;
  int unsigned pv_pct = 0, uv_pct = 0, rdy_pct = 0;
  int          own = 0;           // 0 none, 1 PTP, 2 user
  int unsigned m_hold = 0;
  logic [31:0] m_pcnt = '0, m_ucnt = '0;
  logic        cap = 1'b0;
  logic [1:0]  prev_g = '0;
  logic [1:0]  glog[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic add_frame(input int src, input int len);
    beat_t b;
    logic  u;
    u = 1'($urandom);
    for (int i = 0; i < len; i++) begin
      b.d = {$urandom, $urandom};
      b.l = (i == len - 1);
      b.k = b.l ? 8'(($urandom_range(255, 1))) : 8'hFF;
      b.u = u;
      if (src == 0) pq.push_back(b); else uq.push_back(b);
    end
  endtask

  task automatic drive();
    m_if.tready = ($urandom_range(99) < rdy_pct);
    if (p_acc || !pv) pv = (pq.size() > 0) && ($urandom_range(99) < pv_pct);
    if (u_acc || !uv) uv = (uq.size() > 0) && ($urandom_range(99) < uv_pct);
    ptp_if.tvalid = pv;
    usr_if.tvalid = uv;
    if (pv) begin
      ptp_if.tdata = pq[0].d; ptp_if.tkeep = pq[0].k;
      ptp_if.tlast = pq[0].l; ptp_if.tuser = pq[0].u;
    end else begin
      ptp_if.tdata = {$urandom, $urandom}; ptp_if.tkeep = 8'($urandom);
      ptp_if.tlast = 1'($urandom);         ptp_if.tuser = 1'($urandom);
    end
    if (uv) begin
      usr_if.tdata = uq[0].d; usr_if.tkeep = uq[0].k;
      usr_if.tlast = uq[0].l; usr_if.tuser = uq[0].u;
    end else begin
      usr_if.tdata = {$urandom, $urandom}; usr_if.tkeep = 8'($urandom);
      usr_if.tlast = 1'($urandom);         usr_if.tuser = 1'($urandom);
    end
  endtask

  task automatic step();
    logic       exp_mv, xfer, lst;
    logic [1:0] eg;
    beat_t      b;
    @(negedge clk);
    eg     = (own == 1) ? 2'b01 : (own == 2) ? 2'b10 : 2'b00;
    exp_mv = (own == 1) ? pv : (own == 2) ? uv : 1'b0;
    chk("grant", 64'(grant), 64'(eg));
    chk("ptp_tready", 64'(ptp_if.tready), 64'((own == 1) && m_if.tready));
    chk("usr_tready", 64'(usr_if.tready), 64'((own == 2) && m_if.tready));
    chk("m_tvalid", 64'(m_if.tvalid), 64'(exp_mv));
    chk("ptp_cnt", 64'(pcnt), 64'(m_pcnt));
    chk("usr_cnt", 64'(ucnt), 64'(m_ucnt));
    if (cap && grant != 2'b00 && prev_g == 2'b00) glog.push_back(grant);
    prev_g = grant;
    p_acc = 1'b0; u_acc = 1'b0; lst = 1'b0;
    xfer  = exp_mv && m_if.tready;
    if (exp_mv) begin
      b = (own == 1) ? pq[0] : uq[0];
      chk("m_tdata", m_if.tdata, b.d);
      chk("m_tkeep", 64'(m_if.tkeep), 64'(b.k));
      chk("m_tlast", 64'(m_if.tlast), 64'(b.l));
      chk("m_tuser", 64'(m_if.tuser), 64'({own == 2, b.u}));
      if (xfer) begin
        lst = b.l;
        if (own == 1) begin void'(pq.pop_front()); p_acc = 1'b1; end
        else          begin void'(uq.pop_front()); u_acc = 1'b1; end
      end
    end
    @(posedge clk);
    if (resetn) begin
      if (xfer && lst) begin
        if (own == 1) begin
          m_pcnt++;
          m_hold = uv ? ((m_hold < MAXH) ? m_hold + 1 : m_hold) : 0;
        end else begin
          m_ucnt++;
          m_hold = 0;
        end
        own = 0;
      end else if (own == 0) begin
        if (pv && (m_hold < MAXH || !uv)) own = 1;
        else if (uv) own = 2;
      end
    end
    #1;
    drive();
  endtask

  task automatic run(input int bound);
    int n = 0;
    while ((pq.size() > 0 || uq.size() > 0 || own != 0) && n < bound) begin
      step();
      n++;
    end
    chk("drain_timeout", 64'(pq.size() + uq.size()), 64'd0);
  endtask

  initial begin
    logic [1:0] gexp [10];
    gexp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    resetn = 1'b0;
    m_if.tready = 1'b0;
    drive();
    #2;
    repeat (3) step();
    resetn = 1'b1;

    // user port only, frames of 2/1/5 beats
    uv_pct = 100; rdy_pct = 100;
    add_frame(1, 2); add_frame(1, 1); add_frame(1, 5);
    run(100);
    chk("usr_only_cnt", 64'(ucnt), 64'd3);
    chk("usr_only_ptp", 64'(pcnt), 64'd0);

    // both ports saturated with single-beat frames
    pv_pct = 100; uv_pct = 100; cap = 1'b1;
    for (int i = 0; i < 12; i++) add_frame(0, 1);
    for (int i = 0; i < 3; i++)  add_frame(1, 1);
    run(200);
    cap = 1'b0;
    chk("gseq_len", 64'(glog.size()), 64'd15);
    for (int i = 0; i < 10; i++)
      if (i < glog.size()) chk($sformatf("gseq%0d", i), 64'(glog[i]), 64'(gexp[i]));

    // random traffic with gaps and back-pressure
    pv_pct = 70; uv_pct = 70; rdy_pct = 60;
    for (int i = 0; i < 40; i++) begin
      add_frame(0, $urandom_range(6, 1));
      add_frame(1, $urandom_range(6, 1));
    end
    run(6000);

    // reset asserted on the 2nd beat of a 4-beat frame
    pv_pct = 100; uv_pct = 100; rdy_pct = 100;
    add_frame(1, 4);
    begin
      int n = 0;
      while (uq.size() > 3 && n < 50) begin step(); n++; end
      chk("rst_setup", 64'(uq.size()), 64'd3);
    end
    #2 resetn = 1'b0;
    #1;
    chk("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("rst_usr_tready", 64'(usr_if.tready), 64'd0);
    chk("rst_ptp_tready", 64'(ptp_if.tready), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_ptp_cnt", 64'(pcnt), 64'd0);
    chk("rst_usr_cnt", 64'(ucnt), 64'd0);
    own = 0; m_hold = 0; m_pcnt = '0; m_ucnt = '0;
    pq.delete(); uq.delete();
    pv = 1'b0; uv = 1'b0; p_acc = 1'b0; u_acc = 1'b0;
    ptp_if.tvalid = 1'b0; usr_if.tvalid = 1'b0;
    repeat (2) step();
    resetn = 1'b1;
    add_frame(0, 2); add_frame(1, 3);
    run(100);
    chk("post_rst_ptp", 64'(pcnt), 64'd1);
    chk("post_rst_usr", 64'(ucnt), 64'd1);

    // frame counter wrap
    force dut.u_ptp_cnt.r_cnt = 32'hFFFF_FFFF;
    #1 release dut.u_ptp_cnt.r_cnt;
    m_pcnt = 32'hFFFF_FFFF;
    add_frame(0, 1);
    run(50);
    chk("ptp_wrap", 64'(pcnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
